aes128_byte_loader: RTL and testbench
=====================================

# aes128_byte_loader

Byte-stream front end for `aes128_top`. It accepts a framed byte stream with a valid/ready handshake, assembles the 128-bit key, message and mode, and drives them to the AES core. After a fixed core latency it captures `output_message` and returns the 16 result bytes on a valid/ready output stream. It sits between the system byte interface (UART/FIFO side) and `aes128_top`.

## Interface
- `AES_LATENCY`, default 11: cycles from the last message byte being accepted until `aes_result` is valid; legal range 1..255.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_data` in 8: input stream byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader accepts a byte this cycle.
- `out_data` out 8: result byte.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: consumer accepts `out_data`.
- `out_last` out 1: high with the 16th result byte.
- `busy` out 1: high in any state other than HDR.
- `aes_key` out 128: to `aes128_top.key`.
- `aes_mode` out 1: to `aes128_top.mode`; 0 = encrypt, 1 = decrypt.
- `aes_message` out 128: to `aes128_top.input_message`.
- `aes_result` in 128: from `aes128_top.output_message`.

## Operation
- **Frame format:** 1 header byte, then 16 key bytes (only if header bit1 = 1), then 16 message bytes, all MSB byte first.
  - Header bit0 is the mode.
  - Header bit1 is `key_present`.
  - Header bits 7:2 are ignored.
- **Transfer rules:** an input byte transfers on a rising edge with `in_valid && in_ready`. An output byte transfers on a rising edge with `out_valid && out_ready`.
- **States:**
  - HDR: `in_ready` = 1. On transfer, latch the mode, clear the byte counter, and go to KEY if bit1 = 1, else MSG.
  - KEY: `in_ready` = 1. Each transfer shifts the byte into `aes_key` (`key <= {key[119:0], byte}`). After the 16th byte, go to MSG.
  - MSG: `in_ready` = 1. Shifts into `aes_message` the same way. After the 16th byte, load the latency counter with `AES_LATENCY` and go to WAIT.
  - WAIT: `in_ready` = 0. Decrement the counter each cycle. On the cycle the counter reads 1, capture `aes_result` into the output shift register and go to SEND.
  - SEND: `out_valid` = 1, `out_data` = `obuf[127:120]`. On transfer, shift left 8 and increment the byte counter. The transfer with counter = 15 asserts `out_last`, then returns to HDR.
- **Byte counter:** 4-bit and shared by KEY, MSG and SEND. It wraps 15 -> 0 on state exit.
- **Key reuse:** `aes_key` is retained across frames when `key_present` = 0. After reset the key is all-zero.
- **Held values:** `aes_mode`, `aes_key` and `aes_message` hold their values through WAIT and SEND, and until overwritten by the next frame.
- **Stalls:**
  - `in_valid` low mid-frame stalls with no timeout; state and counter are held.
  - `out_ready` low holds `out_data`, `out_valid` and `out_last` stable.
- **Reset mid-operation:** any state returns to HDR. Key, message, mode, output buffer and counters are cleared. A partial frame is discarded.

## Timing
- **Reset values:**
  - `in_ready` = 0 while `reset` is asserted.
  - `in_ready` = 1 from the first cycle after release, because the loader is in HDR.
  - `out_valid` = 0, `out_last` = 0, `out_data` = 0, `busy` = 0.
  - `aes_key`, `aes_message` and `aes_mode` = 0.
- **Outputs are registered:** all outputs are registered, and `in_ready` is decoded from the state register. There is no combinational path from `in_valid` to `in_ready` or from `out_ready` to `out_valid`.
- **Minimum frame time:**
  - With key: 33 input cycles + `AES_LATENCY` + 16 output cycles.
  - Without key: 17 input cycles + `AES_LATENCY` + 16 output cycles.
- **First output byte:** `out_valid` rises exactly `AES_LATENCY` cycles after the edge that accepted the 16th message byte.
- **Next frame:** the header of the next frame can be accepted on the cycle after the `out_last` transfer.

## Structure
- **Package `aes128_pkg`:**
  - State enum: HDR, KEY, MSG, WAIT, SEND.
  - `BLOCK_BYTES` = 16.
  - Header bit indices: `HDR_MODE_BIT` = 0, `HDR_KEY_BIT` = 1.
  - Any shared `AES_LATENCY` default.
- **Sub-module `aes128_byte_shreg`:** a 128-bit register with byte shift-in (`load_byte`), parallel load, shift-out and async clear. It is instantiated three times: key, message and result.

## Test plan
- **Encrypt, FIPS-197 vector:** header 0x02, key 2b7e151628aed2a6abf7158809cf4f3c, message 3243f6a8885a308d313198a2e0370734 -> output bytes 39 25 84 1d … 0b 32, with `out_last` only on 0x32.
- **Decrypt with key reuse:** header 0x01, message 3925841d02dc09fbdc118597196a0b32 -> output 3243f6a8885a308d313198a2e0370734, using the key from the previous frame.
- **Random back-pressure:** `in_valid` and `out_ready` toggled randomly at 50% -> same bytes as the two cases above. No byte is lost or duplicated, and `out_data` is stable while `out_ready` = 0.
- **Latency check:** `AES_LATENCY` = 11 -> `out_valid` rises exactly 11 cycles after the 16th message byte is accepted. `in_ready` = 0 throughout WAIT and SEND.
- **Reset mid-frame:** reset asserted after message byte 7 -> `in_ready`, `out_valid` and `busy` drop asynchronously and the key reads 0. A following frame with header 0x00 and an all-zero message encrypts under the zero key, giving 66e94bd4ef8a2c3b884cfa59ca342b2e.

Source files
------------

// File: rtl/aes128_pkg.sv
// Shared types and constants for the AES-128 byte-stream loader.
package aes128_pkg;

  localparam int unsigned BYTE_BITS           = 8;
  localparam int unsigned BLOCK_BITS          = 128;
  localparam int unsigned BLOCK_BYTES         = 16;
  localparam int unsigned CNT_W               = 4;
  localparam int unsigned LAT_W               = 8;
  localparam int unsigned HDR_MODE_BIT        = 0;
  localparam int unsigned HDR_KEY_BIT         = 1;
  localparam int unsigned AES_LATENCY_DEFAULT = 11;

  typedef enum logic [2:0] {
    HDR  = 3'd0,
    KEY  = 3'd1,
    MSG  = 3'd2,
    WAIT = 3'd3,
    SEND = 3'd4
  } state_e;

endpackage

// File: rtl/aes128_byte_shreg.sv
// 128-bit register with byte shift-in, parallel load and byte shift-out.
//   clk, rst      : clock, asynchronous active-high clear
//   i_load        : parallel load of i_par (highest priority)
//   i_load_byte   : shift i_byte in at the LSB end, MSB byte falls off
//   i_shift_out   : shift left one byte, zero fill
//   o_q           : register contents
module aes128_byte_shreg
  import aes128_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [BLOCK_BITS-1:0] i_par,
  input  logic                  i_load_byte,
  input  logic [BYTE_BITS-1:0]  i_byte,
  input  logic                  i_shift_out,
  output logic [BLOCK_BITS-1:0] o_q
);

  logic [BLOCK_BITS-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_par;
    end else if (i_load_byte) begin
      r_q <= {r_q[BLOCK_BITS-BYTE_BITS-1:0], i_byte};
    end else if (i_shift_out) begin
      r_q <= {r_q[BLOCK_BITS-BYTE_BITS-1:0], BYTE_BITS'(0)};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/aes128_byte_loader.sv
// Byte-stream front end for aes128_top: assembles header/key/message from a
// valid/ready byte stream, waits the fixed core latency, then streams the
// 16 result bytes out MSB first.
//   clk, reset                      : clock, asynchronous active-high reset
//   in_data/in_valid/in_ready       : input byte stream
//   out_data/out_valid/out_ready    : result byte stream, out_last on byte 16
//   busy                            : high outside the header state
//   aes_key/aes_mode/aes_message    : operands driven to the core
//   aes_result                      : core output, sampled after AES_LATENCY
module aes128_byte_loader
  import aes128_pkg::*;
#(
  parameter int unsigned AES_LATENCY = AES_LATENCY_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BYTE_BITS-1:0]  in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [BYTE_BITS-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic [BLOCK_BITS-1:0] aes_key,
  output logic                  aes_mode,
  output logic [BLOCK_BITS-1:0] aes_message,
  input  logic [BLOCK_BITS-1:0] aes_result
);

  state_e               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [LAT_W-1:0]     r_lat;
  logic                 r_mode;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_out_last;
  logic                 r_busy;

  logic                  w_in_xfer;
  logic                  w_out_xfer;
  logic                  w_cnt_last;
  logic                  w_key_shift;
  logic                  w_msg_shift;
  logic                  w_res_load;
  logic                  w_res_shift;
  logic [BLOCK_BITS-1:0] w_key_q;
  logic [BLOCK_BITS-1:0] w_msg_q;
  logic [BLOCK_BITS-1:0] w_res_q;
  logic                  w_unused_res;

  assign w_in_xfer   = in_valid && r_in_ready;
  assign w_out_xfer  = out_ready && r_out_valid;
  assign w_cnt_last  = (r_cnt == CNT_W'(BLOCK_BYTES - 1));
  assign w_key_shift = w_in_xfer && (r_state == KEY);
  assign w_msg_shift = w_in_xfer && (r_state == MSG);
  // Core output is sampled on the edge where the latency counter reads 1.
  assign w_res_load  = (r_state == WAIT) && (r_lat == LAT_W'(1));
  assign w_res_shift = w_out_xfer && (r_state == SEND);

  aes128_byte_shreg u_key (
    .clk         (clk),
    .rst         (reset),
    .i_load      (1'b0),
    .i_par       ('0),
    .i_load_byte (w_key_shift),
    .i_byte      (in_data),
    .i_shift_out (1'b0),
    .o_q         (w_key_q)
  );

  aes128_byte_shreg u_msg (
    .clk         (clk),
    .rst         (reset),
    .i_load      (1'b0),
    .i_par       ('0),
    .i_load_byte (w_msg_shift),
    .i_byte      (in_data),
    .i_shift_out (1'b0),
    .o_q         (w_msg_q)
  );

  aes128_byte_shreg u_res (
    .clk         (clk),
    .rst         (reset),
    .i_load      (w_res_load),
    .i_par       (aes_result),
    .i_load_byte (1'b0),
    .i_byte      ('0),
    .i_shift_out (w_res_shift),
    .o_q         (w_res_q)
  );

  // Only the top byte of the result buffer is ever presented.
  assign w_unused_res = ^w_res_q[BLOCK_BITS-BYTE_BITS-1:0];

  // Frame sequencer with registered handshake and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= HDR;
      r_cnt       <= '0;
      r_lat       <= '0;
      r_mode      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        HDR: begin
          r_in_ready <= 1'b1;
          if (w_in_xfer) begin
            r_mode <= in_data[HDR_MODE_BIT];
            r_cnt  <= '0;
            r_busy <= 1'b1;
            r_state <= in_data[HDR_KEY_BIT] ? KEY : MSG;
          end
        end
        KEY: begin
          if (w_in_xfer) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_cnt_last) r_state <= MSG;
          end
        end
        MSG: begin
          if (w_in_xfer) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_cnt_last) begin
              r_lat      <= LAT_W'(AES_LATENCY);
              r_in_ready <= 1'b0;
              r_state    <= WAIT;
            end
          end
        end
        WAIT: begin
          r_lat <= r_lat - LAT_W'(1);
          if (r_lat == LAT_W'(1)) begin
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_state     <= SEND;
          end
        end
        SEND: begin
          if (w_out_xfer) begin
            r_cnt      <= r_cnt + CNT_W'(1);
            // Flag the next byte as last when the 15th byte leaves.
            r_out_last <= (r_cnt == CNT_W'(BLOCK_BYTES - 2));
            if (w_cnt_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= HDR;
            end
          end
        end
        default: r_state <= HDR;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
  assign out_data    = w_res_q[BLOCK_BITS-1 -: BYTE_BITS];
  assign busy        = r_busy;
  assign aes_mode    = r_mode;
  assign aes_key     = w_key_q;
  assign aes_message = w_msg_q;

endmodule

// File: tb/tb_aes128_byte_loader.sv
// Bench for aes128_byte_loader: stands in for aes128_top (known FIPS-197
// vectors plus a fixed scramble for random operands, valid only on the
// exact capture cycle) and checks key/message/mode and the output stream.
module tb_aes128_byte_loader;

  localparam int unsigned LAT = 11;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] ZERO_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   in_data = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_last;
  logic         busy;
  logic [127:0] aes_key;
  logic         aes_mode;
  logic [127:0] aes_message;
  logic [127:0] aes_result;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int unsigned arm_cyc = 0;
  bit          arm_valid = 1'b0;
  logic [127:0] core_value = '0;
  logic [127:0] ref_key = '0;

  aes128_byte_loader #(.AES_LATENCY(LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .aes_key     (aes_key),
    .aes_mode    (aes_mode),
    .aes_message (aes_message),
    .aes_result  (aes_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core result is correct only during the cycle before the capture edge.
  assign aes_result = (arm_valid && (cyc - arm_cyc == LAT - 1)) ? core_value : ~core_value;

  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] m,
                                           input logic md);
    if (!md && k == FIPS_KEY && m == FIPS_PT) return FIPS_CT;
    if (md && k == FIPS_KEY && m == FIPS_CT) return FIPS_PT;
    if (!md && k == '0 && m == '0) return ZERO_CT;
    return {m[63:0], m[127:64]} ^ k ^ {128{md}} ^ 128'h0123456789abcdef_fedcba9876543210;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit bp);
    int guard;
    while (bp && $urandom_range(1) == 0) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    guard    = 0;
    while (in_ready !== 1'b1 && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready=%b required=1", in_ready);
    end
    @(negedge clk);
  endtask

  // Sends a frame; nmsg < 16 leaves it partial. Full frames arm the core model.
  task automatic send_frame(input logic [7:0] hdr, input logic [127:0] key,
                            input logic [127:0] msg, input bit bp, input int nmsg);
    logic [127:0] k;
    logic [127:0] m;
    k = key;
    m = msg;
    send_byte(hdr, bp);
    if (hdr[1]) begin
      for (int i = 0; i < 16; i++) begin
        send_byte(k[127:120], bp);
        k = k << 8;
      end
    end
    for (int i = 0; i < nmsg; i++) begin
      send_byte(m[127:120], bp);
      m = m << 8;
    end
    in_valid = 1'b0;
    if (nmsg == 16) begin
      if (hdr[1]) ref_key = key;
      core_value = core_fn(ref_key, msg, hdr[0]);
      arm_cyc    = cyc;
      arm_valid  = 1'b1;
    end
  endtask

  task automatic recv_block(input bit bp, output logic [127:0] data, output bit stable_ok,
                            output bit last_ok, output bit rdy_ok, output bit timed_out);
    int   guard;
    bit   done;
    logic [7:0] hd;
    logic hl;
    data = '0; stable_ok = 1'b1; last_ok = 1'b1; rdy_ok = 1'b1; timed_out = 1'b0;
    for (int i = 0; i < 16; i++) begin
      guard = 0;
      done  = 1'b0;
      while (!done && !timed_out) begin
        out_ready = bp ? 1'($urandom_range(1)) : 1'b1;
        if (out_valid !== 1'b1) begin
          guard++;
          if (guard > 500) timed_out = 1'b1;
          else @(negedge clk);
        end else if (out_ready) begin
          done = 1'b1;
        end else begin
          hd = out_data;
          hl = out_last;
          @(negedge clk);
          if (out_valid !== 1'b1 || out_data !== hd || out_last !== hl) stable_ok = 1'b0;
        end
      end
      if (timed_out) break;
      data = {data[119:0], out_data};
      if (out_last !== (i == 15)) last_ok = 1'b0;
      if (in_ready !== 1'b0) rdy_ok = 1'b0;
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #7;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got rdy=%b ov=%b ol=%b busy=%b required 0 0 0 0",
               in_ready, out_valid, out_last, busy);
    end
    checks++;
    if (out_data !== 8'h00 || aes_key !== '0 || aes_message !== '0 || aes_mode !== 1'b0) begin
      errors++;
      $display("FAIL reset_data got od=%h key=%h msg=%h mode=%b required zeros",
               out_data, aes_key, aes_message, aes_mode);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b busy=%b required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_encrypt_latency;
    logic [127:0] got;
    bit st, lo, ro, to, wait_rdy_ok;
    int n;
    send_frame(8'h02, FIPS_KEY, FIPS_PT, 1'b0, 16);
    checks++;
    if (aes_key !== FIPS_KEY || aes_message !== FIPS_PT || aes_mode !== 1'b0) begin
      errors++;
      $display("FAIL enc_operands got key=%h msg=%h mode=%b required %h %h 0",
               aes_key, aes_message, aes_mode, FIPS_KEY, FIPS_PT);
    end
    n = 0;
    wait_rdy_ok = 1'b1;
    while (out_valid !== 1'b1 && n < 300) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) wait_rdy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != LAT) begin
      errors++;
      $display("FAIL latency got %0d cycles required %0d", n, LAT);
    end
    checks++;
    if (!wait_rdy_ok) begin
      errors++;
      $display("FAIL wait_in_ready got ready/busy wrong in WAIT required rdy=0 busy=1");
    end
    recv_block(1'b0, got, st, lo, ro, to);
    checks++;
    if (to || got !== FIPS_CT) begin
      errors++;
      $display("FAIL enc_result got %h timeout=%b required %h", got, to, FIPS_CT);
    end
    checks++;
    if (!lo || !ro) begin
      errors++;
      $display("FAIL enc_last_ready got last_ok=%b rdy_ok=%b required 1 1", lo, ro);
    end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL enc_next_frame got rdy=%b busy=%b ov=%b required 1 0 0",
               in_ready, busy, out_valid);
    end
  endtask

  task automatic test_decrypt_reuse;
    logic [127:0] got;
    bit st, lo, ro, to;
    send_frame(8'h01, '0, FIPS_CT, 1'b0, 16);
    checks++;
    if (aes_key !== FIPS_KEY || aes_mode !== 1'b1 || aes_message !== FIPS_CT) begin
      errors++;
      $display("FAIL dec_operands got key=%h mode=%b msg=%h required %h 1 %h",
               aes_key, aes_mode, aes_message, FIPS_KEY, FIPS_CT);
    end
    recv_block(1'b0, got, st, lo, ro, to);
    checks++;
    if (to || got !== FIPS_PT || !lo) begin
      errors++;
      $display("FAIL dec_result got %h last_ok=%b required %h", got, lo, FIPS_PT);
    end
  endtask

  task automatic test_backpressure;
    logic [127:0] got;
    bit st, lo, ro, to;
    send_frame(8'h02, FIPS_KEY, FIPS_PT, 1'b1, 16);
    recv_block(1'b1, got, st, lo, ro, to);
    checks++;
    if (to || got !== FIPS_CT || !st || !lo) begin
      errors++;
      $display("FAIL bp_enc got %h stable=%b last=%b required %h 1 1", got, st, lo, FIPS_CT);
    end
    send_frame(8'h01, '0, FIPS_CT, 1'b1, 16);
    recv_block(1'b1, got, st, lo, ro, to);
    checks++;
    if (to || got !== FIPS_PT || !st || !lo) begin
      errors++;
      $display("FAIL bp_dec got %h stable=%b last=%b required %h 1 1", got, st, lo, FIPS_PT);
    end
  endtask

  task automatic test_reset_midframe;
    logic [127:0] got;
    bit st, lo, ro, to;
    send_frame(8'h02, FIPS_KEY, FIPS_PT, 1'b0, 7);
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
        aes_key !== '0 || aes_message !== '0) begin
      errors++;
      $display("FAIL midreset got rdy=%b ov=%b busy=%b key=%h msg=%h required 0 0 0 0 0",
               in_ready, out_valid, busy, aes_key, aes_message);
    end
    ref_key = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_frame(8'h00, '0, '0, 1'b0, 16);
    recv_block(1'b0, got, st, lo, ro, to);
    checks++;
    if (to || got !== ZERO_CT || aes_key !== '0) begin
      errors++;
      $display("FAIL zero_key got %h key=%h required %h key=0", got, aes_key, ZERO_CT);
    end
  endtask

  task automatic test_random;
    logic [127:0] got, k, m, exp;
    logic [7:0] hdr;
    bit st, lo, ro, to, bp;
    for (int f = 0; f < 6; f++) begin
      hdr = 8'($urandom);
      if (f == 0) hdr[1] = 1'b1;
      k   = {$urandom, $urandom, $urandom, $urandom};
      m   = {$urandom, $urandom, $urandom, $urandom};
      bp  = 1'($urandom_range(1));
      exp = core_fn(hdr[1] ? k : ref_key, m, hdr[0]);
      send_frame(hdr, k, m, bp, 16);
      checks++;
      if (aes_key !== ref_key || aes_message !== m || aes_mode !== hdr[0]) begin
        errors++;
        $display("FAIL rand_operands[%0d] got key=%h msg=%h mode=%b required %h %h %b",
                 f, aes_key, aes_message, aes_mode, ref_key, m, hdr[0]);
      end
      recv_block(bp, got, st, lo, ro, to);
      checks++;
      if (to || got !== exp || !st || !lo || !ro) begin
        errors++;
        $display("FAIL rand_result[%0d] got %h st=%b last=%b rdy=%b required %h 1 1 1",
                 f, got, st, lo, ro, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_encrypt_latency();
    test_decrypt_reuse();
    test_backpressure();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish required finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule
